// File: rtl/alu_arbiter_seq.sv
// Two-requester round-robin arbiter that sequences the 8-bit ALU datapath
// through load/execute and returns the captured result with the requester ID.
module alu_arbiter_seq #(
   parameter int EXEC_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [1:0] req0_op,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [1:0] req1_op,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_result,
   output logic       rsp_zero,
   output logic       rsp_carry,
   output logic [7:0] dp_data_a,
   output logic [7:0] dp_data_b,
   output logic       dp_load_a,
   output logic       dp_load_b,
   output logic [1:0] dp_alu_op,
   input  logic [7:0] dp_result,
   input  logic       dp_zero,
   input  logic       dp_carry
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;
   localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
   } cmd_t;

   logic [1:0] state;
   logic [3:0] cnt;
   logic       last_id;
   logic       cur_id;
   logic       gnt_vld;
   logic       gnt_id;
   logic       acc;
   cmd_t [1:0] cmd;
   cmd_t       sel;

   assign cmd[0] = '{a: req0_a, b: req0_b, op: req0_op};
   assign cmd[1] = '{a: req1_a, b: req1_b, op: req1_op};

   // On a tie the requester that was not granted last wins.
   always_comb begin
      gnt_vld = req0_valid | req1_valid;
      gnt_id  = 1'b0;
      if (req0_valid && req1_valid) gnt_id = ~last_id;
      else if (req1_valid)          gnt_id = 1'b1;
   end

   assign req0_ready = rst_n && (state == S_IDLE) && gnt_vld && !gnt_id;
   assign req1_ready = rst_n && (state == S_IDLE) && gnt_vld &&  gnt_id;
   assign acc        = req0_ready | req1_ready;
   assign sel        = cmd[gnt_id];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         last_id    <= 1'b1;
         cur_id     <= 1'b0;
         dp_data_a  <= '0;
         dp_data_b  <= '0;
         dp_alu_op  <= '0;
         dp_load_a  <= 1'b0;
         dp_load_b  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_carry  <= 1'b0;
      end else begin
         dp_load_a <= 1'b0;
         dp_load_b <= 1'b0;
         case (state)
            S_IDLE: if (acc) begin
               dp_data_a <= sel.a;
               dp_data_b <= sel.b;
               dp_alu_op <= sel.op;
               cur_id    <= gnt_id;
               last_id   <= gnt_id;
               dp_load_a <= 1'b1;
               dp_load_b <= 1'b1;
               state     <= S_LOAD;
            end
            S_LOAD: begin
               cnt   <= CNT_INIT;
               state <= S_EXEC;
            end
            // dp_alu_op stays put here so the ALU mux is stable up to capture.
            S_EXEC: if (cnt == 4'd0) begin
               rsp_result <= dp_result;
               rsp_zero   <= dp_zero;
               rsp_carry  <= dp_carry;
               rsp_id     <= cur_id;
               rsp_valid  <= 1'b1;
               state      <= S_RESP;
            end else begin
               cnt <= cnt - 4'd1;
            end
            S_RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
